// File: rtl/dmem_responder.sv
// Data-memory responder: byte-addressed word RAM behind a single-outstanding
// load/store handshake with programmable wait states and one-cycle ack.
module dmem_responder #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              ack,
  output logic              err,
  output logic              busy
);

  localparam int WORDS = 2 ** (ADDR_W - 2);
  localparam int LANES = DATA_W / 8;
  localparam logic [2:0] CNT_INIT = (WAIT_CYC == 0) ? 3'd0 : 3'(WAIT_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic              capture;
  logic              rd_p0, wr_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [2:0]        funct3_p0;
  logic [DATA_W-1:0] wr_data_p0;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem [WORDS];
  logic [DATA_W-1:0] mem_word;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] store_val;
  logic [LANES-1:0]  store_en;
  logic              err_c;
  logic              do_load, do_store;

  function automatic logic decode_err(input logic rdv, input logic wrv,
                                      input logic [2:0] f3, input logic [1:0] a);
    logic e;
    e = 1'b0;
    if (rdv && wrv)                            e = 1'b1;
    else if (rdv && (f3 == 3'b011 || f3[2:1] == 2'b11)) e = 1'b1;
    else if (wrv && f3[1:0] == 2'b11)          e = 1'b1;
    else if (f3[1:0] == 2'b01 && a[0])         e = 1'b1;
    else if (f3[1:0] == 2'b10 && a != 2'b00)   e = 1'b1;
    return e;
  endfunction

  function automatic logic [LANES-1:0] lane_en(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the right-aligned store data into every lane it could land in.
  function automatic logic [DATA_W-1:0] store_lanes(input logic [1:0] sz,
                                                    input logic [DATA_W-1:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input logic [2:0] f3,
                                                    input logic [1:0] a);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{a, 3'b000} +: 8];
    h = word[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return DATA_W'(b);
      3'b001:  return DATA_W'(h);
      3'b100:  return DATA_W'($unsigned(b));
      3'b101:  return DATA_W'($unsigned(h));
      default: return word;
    endcase
  endfunction

  assign capture   = (state == ST_IDLE) && (rd || wr);
  assign err_c     = decode_err(rd_p0, wr_p0, funct3_p0, addr_p0[1:0]);
  assign mem_word  = mem[addr_p0[ADDR_W-1:2]];
  assign load_val  = load_extend(mem_word, funct3_p0, addr_p0[1:0]);
  assign store_val = store_lanes(funct3_p0[1:0], wr_data_p0);
  assign store_en  = lane_en(funct3_p0[1:0], addr_p0[1:0]);
  assign do_load   = (state == ST_RESP) && rd_p0 && !err_c;
  assign do_store  = (state == ST_RESP) && wr_p0 && !err_c;

  // Load result is visible combinationally in the ack cycle, then held.
  assign rd_data = do_load ? load_val : rd_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack       = 1'b0;
    err       = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rd || wr) begin
          if (WAIT_CYC == 0) begin
            state_nxt = ST_RESP;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (cnt == 3'd0) state_nxt = ST_RESP;
        else             cnt_nxt   = cnt - 3'd1;
      end
      ST_RESP: begin
        busy      = 1'b1;
        ack       = 1'b1;
        err       = err_c;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: request capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_p0     <= 1'b0;
      wr_p0     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if (capture) begin
        rd_p0 <= rd;
        wr_p0 <= wr;
      end
      if (do_load) rd_data_q <= load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      addr_p0    <= addr;
      funct3_p0  <= funct3;
      wr_data_p0 <= wr_data;
    end
  end

  // Stage p1: RAM access in the ack cycle
  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int i = 0; i < LANES; i++) begin
        if (store_en[i]) mem[addr_p0[ADDR_W-1:2]][8*i +: 8] <= store_val[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances (WAIT_CYC 0/1/7)
// checked against a byte-array reference model.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        rd [3];
  logic        wr [3];
  logic [8:0]  addr [3];
  logic [2:0]  f3 [3];
  logic [31:0] wd [3];
  logic [31:0] rdd [3];
  logic        ack [3];
  logic        err [3];
  logic        busy [3];

  int WC [3] = '{0, 1, 7};

  logic [7:0]  mref [3][512];
  logic [31:0] last_rd [3];

  int          checks = 0;
  int          failures = 0;
  logic [31:0] got_d, exp_d;
  logic        got_e, exp_e, got_busy;
  int          got_lat;

  dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYC(0)) u0 (
    .clk(clk), .reset(reset), .rd(rd[0]), .wr(wr[0]), .addr(addr[0]), .funct3(f3[0]),
    .wr_data(wd[0]), .rd_data(rdd[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0]));
  dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYC(1)) u1 (
    .clk(clk), .reset(reset), .rd(rd[1]), .wr(wr[1]), .addr(addr[1]), .funct3(f3[1]),
    .wr_data(wd[1]), .rd_data(rdd[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1]));
  dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYC(7)) u2 (
    .clk(clk), .reset(reset), .rd(rd[2]), .wr(wr[2]), .addr(addr[2]), .funct3(f3[2]),
    .wr_data(wd[2]), .rd_data(rdd[2]), .ack(ack[2]), .err(err[2]), .busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: byte array, sizes as byte counts, extension by arithmetic.
  task automatic model(input int k, input logic r, input logic w, input logic [8:0] a,
                       input logic [2:0] f, input logic [31:0] d);
    int sz, nb, ai;
    logic [31:0] v;
    sz = int'(f[1:0]);
    nb = 1 << sz;
    ai = int'(a);
    exp_e = (r && w) || (r && (f == 3 || f == 6 || f == 7)) || (w && sz == 3) ||
            (sz == 1 && ai % 2 != 0) || (sz == 2 && ai % 4 != 0);
    if (!exp_e && w)
      for (int i = 0; i < nb; i++) mref[k][ai + i] = d[8*i +: 8];
    if (!exp_e && r) begin
      v = 0;
      for (int i = 0; i < nb; i++) v = v | (32'(mref[k][ai + i]) << (8 * i));
      if (!f[2] && sz < 2 && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8 * nb));
      last_rd[k] = v;
    end
    exp_d = last_rd[k];
  endtask

  // Drive one request, scramble the inputs after capture, wait (bounded) for ack.
  task automatic run(input int k, input logic r, input logic w, input logic [8:0] a,
                     input logic [2:0] f, input logic [31:0] d);
    int  n;
    bit  started;
    @(negedge clk);
    rd[k] = r; wr[k] = w; addr[k] = a; f3[k] = f; wd[k] = d;
    got_lat = -1; got_d = 'x; got_e = 1'bx; got_busy = 1'bx;
    started = 0; n = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (started) n++;
      else if (busy[k]) begin started = 1; n = 1; end
      if (started) begin
        addr[k] = 9'($urandom); f3[k] = 3'($urandom); wd[k] = $urandom;
      end
      if (ack[k]) begin
        got_lat = n; got_d = rdd[k]; got_e = err[k]; got_busy = busy[k];
        break;
      end
    end
    rd[k] = 0; wr[k] = 0;
    model(k, r, w, a, f, d);
  endtask

  task automatic test_reset;
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      rd[k] = 0; wr[k] = 0; addr[k] = 0; f3[k] = 0; wd[k] = 0; last_rd[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdd[k] !== 32'h0 || ack[k] !== 1'b0 || err[k] !== 1'b0 || busy[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset_state[%0d] rd_data=%h ack=%b err=%b busy=%b required 0/0/0/0",
                 k, rdd[k], ack[k], err[k], busy[k]);
      end
    end
    @(negedge clk); reset = 1;
  endtask

  task automatic test_init;
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 128; w++) begin
        run(k, 0, 1, 9'(w * 4), 3'b010, $urandom);
        if (w % 32 == 0) begin
          checks++;
          if (got_lat !== WC[k] + 1 || got_e !== 1'b0) begin
            failures++;
            $display("FAIL init_store[%0d] lat=%0d err=%b required lat=%0d err=0",
                     k, got_lat, got_e, WC[k] + 1);
          end
        end
      end
  endtask

  task automatic test_word;
    run(1, 0, 1, 9'h010, 3'b010, 32'hDEADBEEF);
    checks++;
    if (got_lat !== 2 || got_e !== 1'b0 || got_busy !== 1'b1) begin
      failures++;
      $display("FAIL sw_word lat=%0d err=%b busy=%b required lat=2 err=0 busy=1", got_lat, got_e, got_busy);
    end
    run(1, 1, 0, 9'h010, 3'b010, 32'h0);
    checks++;
    if (got_lat !== 2 || got_d !== 32'hDEADBEEF || got_e !== 1'b0) begin
      failures++;
      $display("FAIL lw_word lat=%0d data=%h err=%b required lat=2 data=deadbeef err=0", got_lat, got_d, got_e);
    end
  endtask

  task automatic test_byte;
    run(1, 0, 1, 9'h013, 3'b000, 32'hFFFFFF80);
    run(1, 1, 0, 9'h013, 3'b000, 32'h0);
    checks++;
    if (got_d !== 32'hFFFFFF80) begin
      failures++; $display("FAIL lb_sign data=%h required ffffff80", got_d);
    end
    run(1, 1, 0, 9'h013, 3'b100, 32'h0);
    checks++;
    if (got_d !== 32'h00000080) begin
      failures++; $display("FAIL lbu_zero data=%h required 00000080", got_d);
    end
    run(1, 1, 0, 9'h010, 3'b010, 32'h0);
    checks++;
    if (got_d !== 32'h80ADBEEF) begin
      failures++; $display("FAIL sb_lanes data=%h required 80adbeef", got_d);
    end
  endtask

  task automatic test_half;
    logic [15:0] low;
    low = {mref[1][9'h021], mref[1][9'h020]};
    run(1, 0, 1, 9'h022, 3'b001, 32'hABCD1234);
    run(1, 1, 0, 9'h022, 3'b101, 32'h0);
    checks++;
    if (got_d !== 32'h00001234) begin
      failures++; $display("FAIL lhu_zero data=%h required 00001234", got_d);
    end
    run(1, 1, 0, 9'h020, 3'b010, 32'h0);
    checks++;
    if (got_d !== {16'h1234, low}) begin
      failures++; $display("FAIL sh_lanes data=%h required %h", got_d, {16'h1234, low});
    end
    run(1, 0, 1, 9'h012, 3'b001, 32'h0000_9001);
    run(1, 1, 0, 9'h012, 3'b001, 32'h0);
    checks++;
    if (got_d !== 32'hFFFF9001) begin
      failures++; $display("FAIL lh_sign data=%h required ffff9001", got_d);
    end
  endtask

  task automatic test_error;
    logic [31:0] word20;
    word20 = {mref[1][9'h023], mref[1][9'h022], mref[1][9'h021], mref[1][9'h020]};
    run(1, 1, 0, 9'h010, 3'b010, 32'h0);
    run(1, 1, 0, 9'h011, 3'b010, 32'h0);
    checks++;
    if (got_e !== 1'b1 || got_d !== exp_d || got_lat !== 2) begin
      failures++;
      $display("FAIL lw_misaligned err=%b data=%h lat=%0d required err=1 data=%h lat=2", got_e, got_d, got_lat, exp_d);
    end
    run(1, 0, 1, 9'h023, 3'b001, 32'h0000_5555);
    checks++;
    if (got_e !== 1'b1 || got_d !== exp_d) begin
      failures++; $display("FAIL sh_misaligned err=%b data=%h required err=1 data=%h", got_e, got_d, exp_d);
    end
    run(1, 1, 0, 9'h010, 3'b110, 32'h0);
    checks++;
    if (got_e !== 1'b1) begin
      failures++; $display("FAIL ld_illegal err=%b required 1", got_e);
    end
    run(1, 0, 1, 9'h020, 3'b111, 32'h0);
    checks++;
    if (got_e !== 1'b1) begin
      failures++; $display("FAIL st_illegal err=%b required 1", got_e);
    end
    run(1, 1, 0, 9'h020, 3'b010, 32'h0);
    checks++;
    if (got_d !== word20 || got_e !== 1'b0) begin
      failures++; $display("FAIL err_no_write data=%h err=%b required %h err=0", got_d, got_e, word20);
    end
  endtask

  task automatic test_both_latency;
    run(1, 1, 1, 9'h010, 3'b010, 32'h0);
    checks++;
    if (got_e !== 1'b1) begin
      failures++; $display("FAIL rd_wr_both err=%b required 1", got_e);
    end
    for (int j = 0; j < 2; j++) begin
      int k;
      k = (j == 0) ? 0 : 2;
      run(k, 0, 1, 9'h010, 3'b010, 32'hDEADBEEF);
      checks++;
      if (got_lat !== WC[k] + 1) begin
        failures++; $display("FAIL sw_latency[%0d] lat=%0d required %0d", k, got_lat, WC[k] + 1);
      end
      run(k, 1, 0, 9'h010, 3'b010, 32'h0);
      checks++;
      if (got_lat !== WC[k] + 1 || got_d !== 32'hDEADBEEF) begin
        failures++;
        $display("FAIL lw_latency[%0d] lat=%0d data=%h required lat=%0d data=deadbeef", k, got_lat, got_d, WC[k] + 1);
      end
    end
  endtask

  task automatic test_reset_abort;
    run(2, 0, 1, 9'h040, 3'b010, 32'h11223344);
    @(negedge clk);
    wr[2] = 1; addr[2] = 9'h040; f3[2] = 3'b010; wd[2] = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #2 reset = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ack[k] !== 1'b0 || busy[k] !== 1'b0 || rdd[k] !== 32'h0) begin
        failures++;
        $display("FAIL abort_state[%0d] ack=%b busy=%b rd_data=%h required 0/0/0", k, ack[k], busy[k], rdd[k]);
      end
      last_rd[k] = 0;
    end
    wr[2] = 0;
    @(negedge clk); reset = 1;
    run(2, 1, 0, 9'h040, 3'b010, 32'h0);
    checks++;
    if (got_d !== 32'h11223344) begin
      failures++; $display("FAIL abort_no_write data=%h required 11223344", got_d);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 240; n++) begin
      int k, op;
      logic r, w;
      logic [2:0] f;
      logic [8:0] a;
      k  = $urandom_range(0, 2);
      op = $urandom_range(0, 15);
      r  = (op < 8) || (op == 15);
      w  = (op >= 8);
      f  = 3'($urandom);
      a  = 9'($urandom);
      if ($urandom_range(0, 3) != 0) a = a & ~((9'd1 << f[1:0]) - 9'd1);
      run(k, r, w, a, f, $urandom);
      checks++;
      if (got_lat !== WC[k] + 1 || got_e !== exp_e || got_d !== exp_d) begin
        failures++;
        $display("FAIL random[%0d] k=%0d rd=%b wr=%b a=%h f3=%b lat=%0d err=%b data=%h required lat=%0d err=%b data=%h",
                 n, k, r, w, a, f, got_lat, got_e, got_d, WC[k] + 1, exp_e, exp_d);
      end
    end
  endtask

  initial begin
    test_reset;
    test_init;
    test_word;
    test_byte;
    test_half;
    test_error;
    test_both_latency;
    test_reset_abort;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
